// File: rtl/rom_port_arbiter.sv
// rtl/rom_port_arbiter.sv - two-requester arbiter for the shared synchronous instruction ROM read port
module rom_port_arbiter #(
    parameter int ADDR_WIDTH = 10,
    parameter int MAX_WAIT   = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        f_req,
    input  logic [31:0] f_addr,
    output logic        f_gnt,
    output logic        f_rvalid,
    output logic [31:0] f_rdata,
    input  logic        d_req,
    input  logic [31:0] d_addr,
    output logic        d_gnt,
    output logic        d_rvalid,
    output logic [31:0] d_rdata,
    output logic        d_misalign,
    output logic [31:0] rom_addr,
    input  logic [31:0] rom_data
);

    localparam int              CW       = $clog2(MAX_WAIT + 1);
    localparam logic [CW-1:0]   WAIT_MAX = CW'(MAX_WAIT);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWN_F = 2'd1,
        OWN_D = 2'd2
    } owner_e;

    owner_e          state_q, state_d;
    logic [CW-1:0]   wait_cnt_q, wait_cnt_d;
    logic            misalign_q, misalign_d;
    logic [31:0]     sel_addr;

    // Fetch has priority unless D has been denied MAX_WAIT cycles in a row.
    always_comb begin
        f_gnt = 1'b0;
        d_gnt = 1'b0;
        if (!reset) begin
            if (d_req && (wait_cnt_q == WAIT_MAX)) begin
                d_gnt = 1'b1;
            end else if (f_req) begin
                f_gnt = 1'b1;
            end else if (d_req) begin
                d_gnt = 1'b1;
            end
        end
    end

    always_comb begin
        sel_addr = d_gnt ? d_addr : f_addr;

        state_d = IDLE;
        if (f_gnt) begin
            state_d = OWN_F;
        end else if (d_gnt) begin
            state_d = OWN_D;
        end

        misalign_d = d_gnt && (d_addr[1:0] != 2'b00);

        wait_cnt_d = wait_cnt_q;
        if (d_gnt || !d_req) begin
            wait_cnt_d = '0;
        end else if (wait_cnt_q != WAIT_MAX) begin
            wait_cnt_d = wait_cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= IDLE;
            wait_cnt_q <= '0;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            misalign_q <= misalign_d;
        end
    end

    // The ROM decodes only the word field; low and high bits pass through untouched.
    assign rom_addr   = {sel_addr[31:ADDR_WIDTH+2], sel_addr[ADDR_WIDTH+1:2], sel_addr[1:0]};
    assign f_rvalid   = (state_q == OWN_F);
    assign d_rvalid   = (state_q == OWN_D);
    assign d_misalign = misalign_q;
    assign f_rdata    = rom_data;
    assign d_rdata    = rom_data;

endmodule
